relm_fifo_mc: RTL

Multi-channel FIFO I/O block for the ReLM ring: NCH independent FIFOs, each written through its own PE push port and all read or controlled through one shared PE pop port. It replaces the single-channel FIFO I/O block. Each channel has its own full-retry flag; the shared port adds peek, level query and flush. The block uses the ring's `{strobe, data}` port format, so it connects directly to `relm` `push_out` / `push_in` / `pop_out` / `pop_in` slices.

---
 rtl/relm_fifo_mc_if.sv | 31 +++
 rtl/relm_fifo_mc.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/relm_fifo_mc_if.sv
`default_nettype none
// ============================================================================
// relm_fifo_mc_if : port bundle between a ReLM PE and relm_fifo_mc
//                   ({strobe, data} push slices, shared pop command/response)
// Macro RELM_FIFOX_WATERMARK_EN adds the avail_out watermark flags.
// Revision 1.0
// ============================================================================
interface relm_fifo_mc_if #(
    parameter int NCH = 2,
    parameter int WD  = 32
);
    logic [NCH*(WD+1)-1:0] push_d;
    logic [NCH-1:0]        push_retry;
    logic [WD:0]           pop_d;
    logic [WD:0]           pop_q;
    logic [NCH-1:0]        nempty_out;
`ifdef RELM_FIFOX_WATERMARK_EN
    logic [NCH-1:0]        avail_out;

    modport master (output push_d, output pop_d,
                    input  push_retry, input pop_q, input nempty_out, input avail_out);
    modport slave  (input  push_d, input pop_d,
                    output push_retry, output pop_q, output nempty_out, output avail_out);
`else
    modport master (output push_d, output pop_d,
                    input  push_retry, input pop_q, input nempty_out);
    modport slave  (input  push_d, input pop_d,
                    output push_retry, output pop_q, output nempty_out);
`endif
endinterface
`default_nettype wire

// File: rtl/relm_fifo_mc.sv
`default_nettype none
// ============================================================================
// relm_fifo_mc : NCH independent FIFOs, one push port each, one shared
//                pop port with POP / PEEK / LEVEL / CLEAR (+ SETMARK).
// Optional feature macro: RELM_FIFOX_WATERMARK_EN (mark registers, avail_out).
// Revision 1.0
// ============================================================================
module relm_fifo_mc #(
    parameter int NCH = 2,
    parameter int WAD = 4,
    parameter int WD  = 32
) (
    input  logic          clk,
    input  logic          rst,
    relm_fifo_mc_if.slave bus
);
    localparam int WCH   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 1 << WAD;

    localparam logic [2:0] OP_POP     = 3'd0;
    localparam logic [2:0] OP_PEEK    = 3'd1;
    localparam logic [2:0] OP_CLEAR   = 3'd3;
`ifdef RELM_FIFOX_WATERMARK_EN
    localparam logic [2:0] OP_SETMARK = 3'd4;
`endif

    logic           cmd_stb;
    logic [2:0]     cmd_op;
    logic [WCH-1:0] cmd_ch;
    logic           cmd_ok;
    logic           unused_pop_bits;

    assign cmd_stb         = bus.pop_d[WD];
    assign cmd_op          = bus.pop_d[WD-1:WD-3];
    assign cmd_ch          = bus.pop_d[WCH-1:0];
    assign cmd_ok          = cmd_stb && (32'(cmd_ch) < 32'(NCH));
    assign unused_pop_bits = ^bus.pop_d;

    logic [WD-1:0]  head_a  [NCH];
    logic [WAD:0]   level_a [NCH];
    logic [NCH-1:0] nempty;
    logic [NCH-1:0] retry;
`ifdef RELM_FIFOX_WATERMARK_EN
    logic [WAD:0]   mark_a  [NCH];
    logic [NCH-1:0] avail;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WD-1:0] mem [DEPTH];
        logic [WD-1:0] head;
        logic [WAD:0]  ra;
        logic [WAD:0]  wa;
        logic [WAD:0]  ra_next;
        logic [WAD:0]  level;
        logic          ne;
        logic          sel;
        logic          do_pop;
        logic          do_clear;
        logic          push_stb;
        logic          push_ok;
        logic [WD-1:0] push_data;

        assign push_stb  = bus.push_d[c*(WD+1)+WD];
        assign push_data = bus.push_d[c*(WD+1)+:WD];
        assign sel       = cmd_ok && (cmd_ch == WCH'(c));
        assign level     = wa - ra;
        assign do_pop    = sel && (cmd_op == OP_POP) && ne;
        assign do_clear  = sel && (cmd_op == OP_CLEAR);
        // Level never exceeds DEPTH, so its top bit alone means full.
        assign retry[c]  = rst || (level[WAD] && !(do_pop || do_clear));
        assign push_ok   = push_stb && !retry[c] && !do_clear;
        assign ra_next   = do_clear ? wa : (do_pop ? ra + (WAD+1)'(1) : ra);

        always_ff @(posedge clk) begin
            if (rst) begin
                ra <= '0;
                wa <= '0;
                ne <= 1'b0;
            end else begin
                ra <= ra_next;
                if (push_ok) begin
                    wa <= wa + (WAD+1)'(1);
                end
                // Uses pre-edge wa: a word written this edge is not yet in head.
                ne <= (wa != ra_next);
            end
        end

        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem[wa[WAD-1:0]] <= push_data;
            end
            head <= mem[ra_next[WAD-1:0]];
        end

        assign head_a[c]  = head;
        assign level_a[c] = level;
        assign nempty[c]  = ne;

`ifdef RELM_FIFOX_WATERMARK_EN
        logic [WAD:0] mark;
        logic         av;

        always_ff @(posedge clk) begin
            if (rst) begin
                mark <= (WAD+1)'(1);
                av   <= 1'b0;
            end else begin
                if (sel && (cmd_op == OP_SETMARK)) begin
                    mark <= bus.pop_d[WCH+WAD:WCH];
                end
                av <= (mark == '0) || (level >= mark);
            end
        end

        assign mark_a[c] = mark;
        assign avail[c]  = av;
`endif
    end

    logic [WD:0] pop_res;

    always_comb begin
        pop_res = '0;
        if (rst) begin
            pop_res = {1'b1, {WD{1'b0}}};
        end else if (cmd_ok) begin
            case (cmd_op)
                OP_POP, OP_PEEK: pop_res = nempty[cmd_ch] ? {1'b0, head_a[cmd_ch]}
                                                          : {1'b1, {WD{1'b0}}};
`ifdef RELM_FIFOX_WATERMARK_EN
                OP_SETMARK:      pop_res = {1'b0, WD'(mark_a[cmd_ch])};
`endif
                // LEVEL, CLEAR (old level) and the spare opcodes
                default:         pop_res = {1'b0, WD'(level_a[cmd_ch])};
            endcase
        end
    end

    assign bus.pop_q      = pop_res;
    assign bus.push_retry = retry;
    assign bus.nempty_out = nempty;
`ifdef RELM_FIFOX_WATERMARK_EN
    assign bus.avail_out  = avail;
`endif

endmodule
`default_nettype wire
